// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one req/gnt/rvalid memory port between an instruction-side master
// (m0) and a data-side master (m1). One transaction in flight at a time; the
// response is routed back to the master that issued it. A watchdog completes
// hung transactions with an error and then drains the late response.
module mem_port_arbiter #(
  parameter bit          ROUND_ROBIN = 1'b1,
  parameter int unsigned TIMEOUT     = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req_i,
  input  logic [31:0] m0_addr_i,
  input  logic [31:0] m0_wdata_i,
  input  logic        m0_we_i,
  input  logic [3:0]  m0_be_i,
  output logic        m0_gnt_o,
  output logic        m0_rvalid_o,
  output logic [31:0] m0_rdata_o,
  output logic        m0_error_o,
  input  logic        m1_req_i,
  input  logic [31:0] m1_addr_i,
  input  logic [31:0] m1_wdata_i,
  input  logic        m1_we_i,
  input  logic [3:0]  m1_be_i,
  output logic        m1_gnt_o,
  output logic        m1_rvalid_o,
  output logic [31:0] m1_rdata_o,
  output logic        m1_error_o,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_error_i,
  output logic        busy_o,
  output logic        timeout_o
);

  localparam logic [15:0] LP_TIMEOUT = 16'(TIMEOUT);
  localparam bit          LP_WD_EN   = (TIMEOUT != 32'd0);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_REQ      = 2'd1,
    ST_WAIT_RSP = 2'd2,
    ST_DRAIN    = 2'd3
  } state_t;

  state_t      r_state;
  logic        r_owner;
  logic        r_last_gnt;   // master granted most recently; reset value 1 favours m0
  logic [15:0] r_cnt;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic        r_we;
  logic [3:0]  r_be;

  logic        w_winner;
  logic [31:0] w_sel_addr;
  logic [31:0] w_sel_wdata;
  logic        w_sel_we;
  logic [3:0]  w_sel_be;
  logic        w_cnt_hit;
  logic        w_rsp;
  logic        w_tmo;
  logic        w_gnt;
  logic        w_rv;
  logic [31:0] w_rdata;
  logic        w_err;

  // Pick the winner among pending requests (tie: rotate or m1 fixed)
  always_comb begin
    w_winner = 1'b0;
    if (m0_req_i && m1_req_i) begin
      if (ROUND_ROBIN) begin
        w_winner = ~r_last_gnt;
      end else begin
        w_winner = 1'b1;
      end
    end else if (m1_req_i) begin
      w_winner = 1'b1;
    end else begin
      w_winner = 1'b0;
    end
  end

  // Select the attributes of the winning master for latching
  always_comb begin
    if (w_winner) begin
      w_sel_addr  = m1_addr_i;
      w_sel_wdata = m1_wdata_i;
      w_sel_we    = m1_we_i;
      w_sel_be    = m1_be_i;
    end else begin
      w_sel_addr  = m0_addr_i;
      w_sel_wdata = m0_wdata_i;
      w_sel_we    = m0_we_i;
      w_sel_be    = m0_be_i;
    end
  end

  // A real response in WAIT_RSP always beats a watchdog expiry in the same cycle
  assign w_cnt_hit = LP_WD_EN && (r_cnt == LP_TIMEOUT);
  assign w_rsp     = (r_state == ST_WAIT_RSP) && mem_rvalid_i;
  assign w_tmo     = (r_state == ST_WAIT_RSP) && !mem_rvalid_i && w_cnt_hit;
  assign w_gnt     = (r_state == ST_REQ) && mem_gnt_i;
  assign w_rv      = w_rsp || w_tmo;
  assign w_rdata   = w_rsp ? mem_rdata_i : 32'd0;
  assign w_err     = w_rsp ? mem_error_i : w_tmo;

  // Transaction FSM with latched request attributes and watchdog counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_owner    <= 1'b0;
      r_last_gnt <= 1'b1;
      r_cnt      <= 16'd0;
      r_addr     <= 32'd0;
      r_wdata    <= 32'd0;
      r_we       <= 1'b0;
      r_be       <= 4'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (m0_req_i || m1_req_i) begin
            r_owner    <= w_winner;
            r_last_gnt <= w_winner;
            r_addr     <= w_sel_addr;
            r_wdata    <= w_sel_wdata;
            r_we       <= w_sel_we;
            r_be       <= w_sel_be;
            r_state    <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (mem_gnt_i) begin
            r_cnt   <= 16'd0;
            r_state <= ST_WAIT_RSP;
          end
        end
        ST_WAIT_RSP: begin
          if (mem_rvalid_i) begin
            r_state <= ST_IDLE;
          end else if (w_cnt_hit) begin
            r_cnt   <= 16'd0;
            r_state <= ST_DRAIN;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        ST_DRAIN: begin
          // Late response (or a second expiry) is swallowed here
          if (mem_rvalid_i || w_cnt_hit) begin
            r_cnt   <= 16'd0;
            r_state <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Route grant and response to the owner; the other master sees zeros
  always_comb begin
    m0_gnt_o    = 1'b0;
    m0_rvalid_o = 1'b0;
    m0_rdata_o  = 32'd0;
    m0_error_o  = 1'b0;
    m1_gnt_o    = 1'b0;
    m1_rvalid_o = 1'b0;
    m1_rdata_o  = 32'd0;
    m1_error_o  = 1'b0;
    if (r_owner) begin
      m1_gnt_o    = w_gnt;
      m1_rvalid_o = w_rv;
      m1_rdata_o  = w_rdata;
      m1_error_o  = w_err;
    end else begin
      m0_gnt_o    = w_gnt;
      m0_rvalid_o = w_rv;
      m0_rdata_o  = w_rdata;
      m0_error_o  = w_err;
    end
  end

  assign mem_req_o   = (r_state == ST_REQ);
  assign mem_addr_o  = r_addr;
  assign mem_wdata_o = r_wdata;
  assign mem_we_o    = r_we;
  assign mem_be_o    = r_be;
  assign busy_o      = (r_state != ST_IDLE);
  assign timeout_o   = w_tmo;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter. Instance A: round-robin,
// TIMEOUT=4. Instance B: fixed priority, watchdog off, with a simple
// always-ready memory model. Expected grants and responses are queued when
// stimulus is driven and compared when the DUT produces them.
module tb_mem_port_arbiter;

  logic clk;
  logic reset;

  // Instance A signals
  logic        a_m0_req, a_m0_we, a_m1_req, a_m1_we;
  logic [31:0] a_m0_addr, a_m0_wdata, a_m1_addr, a_m1_wdata;
  logic [3:0]  a_m0_be, a_m1_be;
  logic        a_m0_gnt, a_m0_rvalid, a_m0_err, a_m1_gnt, a_m1_rvalid, a_m1_err;
  logic [31:0] a_m0_rdata, a_m1_rdata;
  logic        a_mem_req, a_mem_we, a_mem_gnt, a_mem_rvalid, a_mem_err;
  logic [31:0] a_mem_addr, a_mem_wdata, a_mem_rdata;
  logic [3:0]  a_mem_be;
  logic        a_busy, a_tmo;

  // Instance B signals
  logic        b_m0_req, b_m1_req;
  logic        b_m0_gnt, b_m0_rvalid, b_m0_err, b_m1_gnt, b_m1_rvalid, b_m1_err;
  logic [31:0] b_m0_rdata, b_m1_rdata;
  logic        b_mem_req, b_mem_we, b_mem_gnt, b_mem_rvalid, b_mem_err;
  logic [31:0] b_mem_addr, b_mem_wdata, b_mem_rdata;
  logic [3:0]  b_mem_be;
  logic        b_busy, b_tmo;

  logic [63:0] a_outs;
  assign a_outs = {a_mem_addr | a_mem_wdata | a_m0_rdata | a_m1_rdata, 18'd0, a_mem_be,
                   a_m0_gnt, a_m0_rvalid, a_m0_err, a_m1_gnt, a_m1_rvalid, a_m1_err,
                   a_mem_req, a_mem_we, a_busy, a_tmo};

  // B memory: always accepts, answers in the first WAIT_RSP cycle
  assign b_mem_gnt    = 1'b1;
  assign b_mem_rvalid = b_busy & ~b_mem_req;
  assign b_mem_rdata  = 32'd0;
  assign b_mem_err    = 1'b0;

  mem_port_arbiter #(.ROUND_ROBIN(1'b1), .TIMEOUT(4)) u_dut_a (
    .clk(clk), .reset(reset),
    .m0_req_i(a_m0_req), .m0_addr_i(a_m0_addr), .m0_wdata_i(a_m0_wdata), .m0_we_i(a_m0_we), .m0_be_i(a_m0_be),
    .m0_gnt_o(a_m0_gnt), .m0_rvalid_o(a_m0_rvalid), .m0_rdata_o(a_m0_rdata), .m0_error_o(a_m0_err),
    .m1_req_i(a_m1_req), .m1_addr_i(a_m1_addr), .m1_wdata_i(a_m1_wdata), .m1_we_i(a_m1_we), .m1_be_i(a_m1_be),
    .m1_gnt_o(a_m1_gnt), .m1_rvalid_o(a_m1_rvalid), .m1_rdata_o(a_m1_rdata), .m1_error_o(a_m1_err),
    .mem_req_o(a_mem_req), .mem_addr_o(a_mem_addr), .mem_wdata_o(a_mem_wdata), .mem_we_o(a_mem_we),
    .mem_be_o(a_mem_be), .mem_gnt_i(a_mem_gnt), .mem_rvalid_i(a_mem_rvalid), .mem_rdata_i(a_mem_rdata),
    .mem_error_i(a_mem_err), .busy_o(a_busy), .timeout_o(a_tmo)
  );

  mem_port_arbiter #(.ROUND_ROBIN(1'b0), .TIMEOUT(0)) u_dut_b (
    .clk(clk), .reset(reset),
    .m0_req_i(b_m0_req), .m0_addr_i(32'h0000_0C00), .m0_wdata_i(32'd0), .m0_we_i(1'b0), .m0_be_i(4'hF),
    .m0_gnt_o(b_m0_gnt), .m0_rvalid_o(b_m0_rvalid), .m0_rdata_o(b_m0_rdata), .m0_error_o(b_m0_err),
    .m1_req_i(b_m1_req), .m1_addr_i(32'h0000_0D00), .m1_wdata_i(32'd0), .m1_we_i(1'b0), .m1_be_i(4'hF),
    .m1_gnt_o(b_m1_gnt), .m1_rvalid_o(b_m1_rvalid), .m1_rdata_o(b_m1_rdata), .m1_error_o(b_m1_err),
    .mem_req_o(b_mem_req), .mem_addr_o(b_mem_addr), .mem_wdata_o(b_mem_wdata), .mem_we_o(b_mem_we),
    .mem_be_o(b_mem_be), .mem_gnt_i(b_mem_gnt), .mem_rvalid_i(b_mem_rvalid), .mem_rdata_i(b_mem_rdata),
    .mem_error_i(b_mem_err), .busy_o(b_busy), .timeout_o(b_tmo)
  );

  typedef struct { logic m; logic [31:0] d; logic e; logic t; } rsp_t;
  typedef struct { logic m; logic [31:0] a; } gnt_t;

  rsp_t rsp_q[$];
  gnt_t gnt_q[$];
  logic b_gq[$];
  int   b_gcnt;
  int   vectors;
  int   errors;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation did not finish");
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Per-cycle scoreboard compare for both instances
  task automatic mon();
    rsp_t e;
    gnt_t g;
    check_eq("gnt_follow", 64'(a_m0_gnt | a_m1_gnt), 64'(a_mem_gnt & a_mem_req));
    if (a_m0_gnt || a_m1_gnt) begin
      check_eq("gnt_onehot", 64'(a_m0_gnt & a_m1_gnt), 64'd0);
      if (gnt_q.size() == 0) begin
        check_eq("gnt_unexpected", 64'd1, 64'd0);
      end else begin
        g = gnt_q.pop_front();
        check_eq("gnt_master", 64'(a_m1_gnt), 64'(g.m));
        check_eq("gnt_addr", 64'(a_mem_addr), 64'(g.a));
      end
    end
    if (a_m0_rvalid || a_m1_rvalid) begin
      check_eq("rsp_onehot", 64'(a_m0_rvalid & a_m1_rvalid), 64'd0);
      if (rsp_q.size() == 0) begin
        check_eq("rsp_unexpected", 64'd1, 64'd0);
      end else begin
        e = rsp_q.pop_front();
        check_eq("rsp_master", 64'(a_m1_rvalid), 64'(e.m));
        check_eq("rsp_rdata", 64'(e.m ? a_m1_rdata : a_m0_rdata), 64'(e.d));
        check_eq("rsp_error", 64'(e.m ? a_m1_err : a_m0_err), 64'(e.e));
        check_eq("rsp_timeout", 64'(a_tmo), 64'(e.t));
        check_eq("rsp_other_zero", {31'd0, (e.m ? a_m0_err : a_m1_err), (e.m ? a_m0_rdata : a_m1_rdata)}, 64'd0);
      end
    end else begin
      check_eq("idle_rdata_tmo", {31'd0, a_tmo, a_m0_rdata | a_m1_rdata}, 64'd0);
    end
    if (b_m0_gnt || b_m1_gnt) begin
      b_gcnt++;
      if (b_gq.size() == 0) begin
        check_eq("b_gnt_unexpected", 64'd1, 64'd0);
      end else begin
        check_eq("b_gnt_order", 64'(b_m1_gnt), 64'(b_gq.pop_front()));
      end
    end
  endtask

  task automatic sample();
    @(negedge clk);
    mon();
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    sample();
    advance();
  endtask

  // Memory side for instance A: wait for mem_req_o, grant after gdly, answer after rdly
  task automatic serve(input int gdly, input int rdly, input logic [31:0] d, input logic e, input bit drop);
    int   n;
    logic g1;
    n = 0;
    while (!a_mem_req && n < 20) begin
      tick();
      n++;
    end
    check_eq("serve_req_seen", 64'(a_mem_req), 64'd1);
    repeat (gdly) tick();
    a_mem_gnt = 1'b1;
    sample();
    g1 = a_m1_gnt;
    advance();
    a_mem_gnt = 1'b0;
    if (drop) begin
      if (g1) a_m1_req = 1'b0;
      else    a_m0_req = 1'b0;
    end
    repeat (rdly) tick();
    a_mem_rvalid = 1'b1;
    a_mem_rdata  = d;
    a_mem_err    = e;
    tick();
    a_mem_rvalid = 1'b0;
    a_mem_rdata  = 32'd0;
    a_mem_err    = 1'b0;
  endtask

  initial begin
    int n;
    vectors = 0; errors = 0; b_gcnt = 0;
    reset = 1'b1;
    a_m0_req = 1'b0; a_m0_addr = 32'd0; a_m0_wdata = 32'd0; a_m0_we = 1'b0; a_m0_be = 4'd0;
    a_m1_req = 1'b0; a_m1_addr = 32'd0; a_m1_wdata = 32'd0; a_m1_we = 1'b0; a_m1_be = 4'd0;
    a_mem_gnt = 1'b0; a_mem_rvalid = 1'b0; a_mem_rdata = 32'd0; a_mem_err = 1'b0;
    b_m0_req = 1'b0; b_m1_req = 1'b0;

    // Reset state
    sample();
    check_eq("rst_outs", a_outs, 64'd0);
    advance();
    reset = 1'b0;
    tick();

    // Round-robin contention: m0, m1, m0, m1
    a_m0_req = 1'b1; a_m0_addr = 32'h0000_00A0; a_m0_be = 4'hF;
    a_m1_req = 1'b1; a_m1_addr = 32'h0000_00B0; a_m1_be = 4'hF;
    for (int i = 0; i < 4; i++) begin
      gnt_q.push_back('{m: 1'(i % 2), a: (i % 2 == 1) ? 32'h0000_00B0 : 32'h0000_00A0});
      rsp_q.push_back('{m: 1'(i % 2), d: 32'h0000_1000 + 32'(i), e: 1'b0, t: 1'b0});
    end
    for (int i = 0; i < 4; i++) serve(0, 0, 32'h0000_1000 + 32'(i), 1'b0, 1'b0);
    a_m0_req = 1'b0; a_m1_req = 1'b0;
    tick();

    // Fixed priority on B: m1 x4, then m0 once m1 drops
    for (int i = 0; i < 4; i++) b_gq.push_back(1'b1);
    b_gq.push_back(1'b0);
    b_m0_req = 1'b1; b_m1_req = 1'b1;
    n = 0;
    while (b_gcnt < 4 && n < 60) begin tick(); n++; end
    check_eq("b_four_m1_grants", 64'(b_gcnt), 64'd4);
    b_m1_req = 1'b0;
    n = 0;
    while (b_gcnt < 5 && n < 20) begin tick(); n++; end
    check_eq("b_m0_granted", 64'(b_gcnt), 64'd5);
    b_m0_req = 1'b0;
    repeat (3) tick();

    // Single read on A with busy profile
    a_m0_req = 1'b1; a_m0_addr = 32'h0000_0100; a_m0_we = 1'b0;
    gnt_q.push_back('{m: 1'b0, a: 32'h0000_0100});
    rsp_q.push_back('{m: 1'b0, d: 32'hDEAD_BEEF, e: 1'b0, t: 1'b0});
    sample(); check_eq("t1_busy_c0", 64'(a_busy), 64'd0); advance();
    a_mem_gnt = 1'b1;
    sample(); check_eq("t1_busy_c1", 64'(a_busy), 64'd1); check_eq("t1_memreq_c1", 64'(a_mem_req), 64'd1); advance();
    a_mem_gnt = 1'b0; a_m0_req = 1'b0;
    sample(); check_eq("t1_busy_c2", 64'(a_busy), 64'd1); check_eq("t1_memreq_c2", 64'(a_mem_req), 64'd0); advance();
    a_mem_rvalid = 1'b1; a_mem_rdata = 32'hDEAD_BEEF;
    sample(); check_eq("t1_busy_c3", 64'(a_busy), 64'd1); advance();
    a_mem_rvalid = 1'b0; a_mem_rdata = 32'd0;
    sample(); check_eq("t1_busy_c4", 64'(a_busy), 64'd0); advance();

    // Write passthrough with grant held off three cycles
    a_m1_req = 1'b1; a_m1_addr = 32'h0000_2004; a_m1_wdata = 32'h1234_5678; a_m1_we = 1'b1; a_m1_be = 4'b0110;
    gnt_q.push_back('{m: 1'b1, a: 32'h0000_2004});
    rsp_q.push_back('{m: 1'b1, d: 32'd0, e: 1'b0, t: 1'b0});
    tick();
    for (int k = 1; k <= 4; k++) begin
      a_mem_gnt = (k == 4);
      sample();
      check_eq("t3_memreq", 64'(a_mem_req), 64'd1);
      check_eq("t3_addr_wdata", {a_mem_addr, a_mem_wdata}, {32'h0000_2004, 32'h1234_5678});
      check_eq("t3_we_be", {59'd0, a_mem_we, a_mem_be}, {59'd0, 1'b1, 4'b0110});
      check_eq("t3_m1_gnt", 64'(a_m1_gnt), 64'(k == 4));
      advance();
    end
    a_mem_gnt = 1'b0; a_m1_req = 1'b0; a_m1_we = 1'b0;
    a_mem_rvalid = 1'b1;
    sample(); check_eq("t3_memreq_off", 64'(a_mem_req), 64'd0); advance();
    a_mem_rvalid = 1'b0;
    tick();

    // Watchdog: no response, error completion on 5th WAIT_RSP cycle, late rsp dropped
    a_m0_req = 1'b1; a_m0_addr = 32'h0000_0300;
    gnt_q.push_back('{m: 1'b0, a: 32'h0000_0300});
    rsp_q.push_back('{m: 1'b0, d: 32'd0, e: 1'b1, t: 1'b1});
    tick();
    a_mem_gnt = 1'b1;
    tick();
    a_mem_gnt = 1'b0; a_m0_req = 1'b0;
    repeat (4) tick();
    sample(); check_eq("t4_tmo_pulse", 64'(a_tmo), 64'd1); advance();
    tick();
    a_mem_rvalid = 1'b1; a_mem_rdata = 32'hBAD0_BAD0;
    sample(); check_eq("t4_drain_busy", 64'(a_busy), 64'd1); advance();
    a_mem_rvalid = 1'b0; a_mem_rdata = 32'd0;
    sample(); check_eq("t4_idle_after_drain", 64'(a_busy), 64'd0); advance();
    a_m0_req = 1'b1; a_m0_addr = 32'h0000_0304;
    gnt_q.push_back('{m: 1'b0, a: 32'h0000_0304});
    rsp_q.push_back('{m: 1'b0, d: 32'hCAFE_0001, e: 1'b0, t: 1'b0});
    serve(0, 1, 32'hCAFE_0001, 1'b0, 1'b1);

    // Error response in the same cycle the counter reaches TIMEOUT
    a_m1_req = 1'b1; a_m1_addr = 32'h0000_0400;
    gnt_q.push_back('{m: 1'b1, a: 32'h0000_0400});
    rsp_q.push_back('{m: 1'b1, d: 32'h5555_AAAA, e: 1'b1, t: 1'b0});
    serve(0, 4, 32'h5555_AAAA, 1'b1, 1'b1);
    sample(); check_eq("t5_idle", 64'(a_busy), 64'd0); advance();

    // Reset during WAIT_RSP, then a stray response in IDLE
    a_m0_req = 1'b1; a_m0_addr = 32'h0000_0500;
    gnt_q.push_back('{m: 1'b0, a: 32'h0000_0500});
    tick();
    a_mem_gnt = 1'b1;
    tick();
    a_mem_gnt = 1'b0; a_m0_req = 1'b0;
    sample();
    check_eq("t6_addr_held", {31'd0, a_mem_req, a_mem_addr}, {31'd0, 1'b0, 32'h0000_0500});
    advance();
    reset = 1'b1;
    #1;
    check_eq("t6_async_reset_outs", a_outs, 64'd0);
    sample();
    advance();
    reset = 1'b0;
    a_mem_rvalid = 1'b1; a_mem_rdata = 32'h0000_0077;
    sample(); check_eq("t6_stray_ignored", 64'(a_busy), 64'd0); advance();
    a_mem_rvalid = 1'b0; a_mem_rdata = 32'd0;
    tick();

    check_eq("rsp_q_empty", 64'(rsp_q.size()), 64'd0);
    check_eq("gnt_q_empty", 64'(gnt_q.size()), 64'd0);
    check_eq("b_gq_empty", 64'(b_gq.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares the single external memory port between two requesters: master 0 (instruction-side cache) and master 1 (data-side cache). Both masters use the same req/gnt/rvalid protocol as the cache memory side. The block keeps at most one transaction outstanding and routes the response back to its owner. A response watchdog ends hung transactions with an error.

Parameters:
ROUND_ROBIN, 1, 1 = round-robin between masters; 0 = fixed priority, master 1 wins.
TIMEOUT, 255, number of WAIT_RSP cycles without a response before an error completion. 0 disables the watchdog. Range 0..65535 (16-bit counter).

Ports:
clk  in  1  clock, rising edge.
reset  in  1  asynchronous, active-high reset.
mN_req_i  in  1  request (N = 0, 1). Held high, with stable attributes, until mN_gnt_o.
mN_addr_i  in  32  word address.
mN_wdata_i  in  32  write data.
mN_we_i  in  1  1 = write.
mN_be_i  in  4  byte enables.
mN_gnt_o  out  1  request accepted.
mN_rvalid_o  out  1  response valid, 1 cycle.
mN_rdata_o  out  32  read data.
mN_error_o  out  1  error, qualified by mN_rvalid_o.
mem_req_o  out  1  memory request.
mem_addr_o  out  32  memory address.
mem_wdata_o  out  32  memory write data.
mem_we_o  out  1  memory write enable.
mem_be_o  out  4  memory byte enables.
mem_gnt_i  in  1  memory accepted the request.
mem_rvalid_i  in  1  memory response valid.
mem_rdata_i  in  32  memory read data.
mem_error_i  in  1  memory error, qualified by mem_rvalid_i.
busy_o  out  1  high whenever state != IDLE.
timeout_o  out  1  1-cycle pulse when the watchdog fires.

Behaviour:
- Reset: state IDLE, owner 0, priority pointer favours m0, counter 0, latched attributes 0. All outputs 0.
- Reset mid-transaction aborts the transaction with no response to any master.
- States: IDLE, REQ, WAIT_RSP, DRAIN.
- IDLE:
  - If any mN_req_i is high, pick a winner, latch its addr/wdata/we/be, record it as owner, go to REQ.
  - Round-robin mode: on a tie, the master not granted last wins; the pointer updates on each arbitration.
  - Fixed mode: m1 wins ties.
- REQ:
  - mem_req_o = 1; mem_* outputs drive the latched attributes.
  - mem_addr_o/wdata/we/be hold the latched values in every state; they are 0 only after reset.
  - Owner's mN_gnt_o = mem_gnt_i (combinational, same cycle). On mem_gnt_i go to WAIT_RSP and clear the counter.
  - The loser's gnt stays 0, and its request stays pending.
- WAIT_RSP:
  - mem_req_o = 0.
  - On mem_rvalid_i: owner's rvalid_o = 1, rdata_o = mem_rdata_i, error_o = mem_error_i, all in the same cycle. Then go to IDLE.
  - Otherwise the counter increments.
  - If TIMEOUT != 0 and counter == TIMEOUT with no rvalid: owner's rvalid_o = 1, error_o = 1, rdata_o = 0, timeout_o = 1. Then go to DRAIN with the counter cleared.
  - If mem_rvalid_i arrives in the same cycle the counter hits TIMEOUT, the real response wins and there is no timeout.
- DRAIN:
  - Waits for the late response and discards it. No master outputs are driven.
  - Goes to IDLE on mem_rvalid_i, or when the counter reaches TIMEOUT again.
- mem_rvalid_i in IDLE or REQ is ignored.
- Master outputs: rdata_o is 0 whenever rvalid_o is 0. The non-owner's gnt/rvalid/error are always 0.
- Latency for an immediate mem_gnt_i: req at cycle 0, mem_req_o and gnt at cycle 1, earliest response at cycle 2, next arbitration at cycle 3.

Test Plan:
1. Single read: m0 reads addr 0x100, mem_gnt_i at cycle 1, rvalid at cycle 3 with data 0xDEADBEEF -> m0_gnt_o at cycle 1; m0_rvalid_o at cycle 3 with rdata 0xDEADBEEF and error 0; m1 outputs stay 0; busy_o high cycles 1–3.
2. Contention, round-robin: both masters request continuously for 4 transactions -> grant order m0, m1, m0, m1. With ROUND_ROBIN=0 -> m1, m1, m1, m1, and m0 is granted only after m1 drops its request.
3. Write passthrough: m1 writes addr 0x2004, wdata 0x12345678, be 4'b0110, and mem_gnt_i is held off 3 cycles -> mem_req_o stays high with stable attributes for 4 cycles; m1_gnt_o is high only in the mem_gnt_i cycle.
4. Timeout: TIMEOUT=4, no mem_rvalid_i -> on the 5th WAIT_RSP cycle, owner rvalid_o = 1, error_o = 1, rdata_o = 0, and timeout_o pulses. A late rvalid 2 cycles later is discarded. The next request is served normally.
5. Error and simultaneity: mem_rvalid_i with mem_error_i = 1 in the same cycle the counter equals TIMEOUT -> owner gets error_o = 1 and timeout_o stays 0.
6. Reset mid-transaction: assert reset in WAIT_RSP -> all outputs 0 immediately (asynchronously). A stray rvalid after release is ignored in IDLE.
